// File: rtl/trace_pkg.sv
// Shared encodings for the pipeline trace buffer.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  typedef enum logic [1:0] {
    MODE_CONT    = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_TRIG    = 2'd2,
    MODE_RSVD    = 2'd3
  } trace_mode_e;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: register array, synchronous write, asynchronous read, no reset.
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Pipeline trace buffer: captures {pc, instr} samples in CONT/ONESHOT/TRIG
// modes, then drains them oldest-first through a valid/ready read port.
module pipeline_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cap_valid,
  input  logic [PC_W-1:0]            cap_pc,
  input  logic [INSTR_W-1:0]         cap_instr,
  input  logic [1:0]                 mode,
  input  logic [PC_W-1:0]            trig_pc,
  input  logic                       arm,
  input  logic                       stop,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [PC_W-1:0]            rd_pc,
  output logic [INSTR_W-1:0]         rd_instr,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 state,
  output logic                       triggered,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = PC_W + INSTR_W;

  trace_state_e  state_q;
  trace_mode_e   cur_mode;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] post_cnt;
  logic [CW-1:0] count_q;
  logic          triggered_q;
  logic          overflow_q;
  logic          capturing;
  logic          wr_en;
  logic          full;
  logic          trig_hit;
  logic [DW-1:0] rd_data;

  assign cur_mode  = trace_mode_e'(mode);
  assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign wr_en     = capturing && cap_valid;
  assign full      = (count_q == CW'(DEPTH));
  assign trig_hit  = wr_en && (state_q == ST_ARMED) && (cur_mode == MODE_TRIG)
                     && (cap_pc == trig_pc);
  // Oldest entry sits count slots behind the write pointer
  assign rd_ptr    = wr_ptr - count_q[AW-1:0];

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (DW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({cap_pc, cap_instr}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Capture / readout control FSM with its bookkeeping registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wr_ptr      <= '0;
      count_q     <= '0;
      post_cnt    <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_q     <= ST_ARMED;
            wr_ptr      <= '0;
            count_q     <= '0;
            post_cnt    <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
          end
        end
        ST_ARMED, ST_POST: begin
          if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (!full)                          count_q    <= count_q + CW'(1);
            else if (cur_mode != MODE_ONESHOT)  overflow_q <= 1'b1;
          end
          if (trig_hit) triggered_q <= 1'b1;
          if (stop) begin
            state_q <= ST_DONE;
          end else if (wr_en) begin
            if ((cur_mode == MODE_ONESHOT) && (count_q == CW'(DEPTH - 1)))
              state_q <= ST_DONE;
            if (trig_hit) begin
              if (POST_TRIG == 0) begin
                state_q <= ST_DONE;
              end else begin
                state_q  <= ST_POST;
                post_cnt <= AW'(POST_TRIG);
              end
            end
            if (state_q == ST_POST) begin
              post_cnt <= post_cnt - AW'(1);
              if (post_cnt == AW'(1)) state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (arm) begin
            state_q     <= ST_ARMED;
            wr_ptr      <= '0;
            count_q     <= '0;
            post_cnt    <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
          end else if (count_q == '0) begin
            state_q <= ST_IDLE;
          end else if (rd_ready) begin
            count_q <= count_q - CW'(1);
            if (count_q == CW'(1)) state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign rd_valid  = (state_q == ST_DONE) && (count_q != '0);
  assign rd_pc     = rd_data[DW-1:INSTR_W];
  assign rd_instr  = rd_data[INSTR_W-1:0];
  assign count     = count_q;
  assign state     = state_q;
  assign triggered = triggered_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed bench for pipeline_trace_buffer (DEPTH=16, POST_TRIG=4).
module tb_pipeline_trace_buffer;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned DEPTH   = 16;

  logic                 clk;
  logic                 reset;
  logic                 cap_valid;
  logic [PC_W-1:0]      cap_pc;
  logic [INSTR_W-1:0]   cap_instr;
  logic [1:0]           mode;
  logic [PC_W-1:0]      trig_pc;
  logic                 arm;
  logic                 stop;
  logic                 rd_ready;
  logic                 rd_valid;
  logic [PC_W-1:0]      rd_pc;
  logic [INSTR_W-1:0]   rd_instr;
  logic [4:0]           count;
  logic [1:0]           state;
  logic                 triggered;
  logic                 overflow;

  int n_checks;
  int n_errors;

  pipeline_trace_buffer #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .POST_TRIG(4)
  ) dut (
    .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_instr(cap_instr), .mode(mode), .trig_pc(trig_pc), .arm(arm),
    .stop(stop), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc),
    .rd_instr(rd_instr), .count(count), .state(state),
    .triggered(triggered), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] trig;
    int          nsamp;
    bit          do_stop;
    int          exp_cnt;
    bit          exp_ovf;
    bit          exp_trig;
    logic [31:0] exp_first;
  } vec_t;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_5A00;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic feed(input int first_idx, input int n);
    for (int i = 0; i < n; i++) begin
      cap_valid = 1'b1;
      cap_pc    = 32'((first_idx + i) * 4);
      cap_instr = instr_of(cap_pc);
      step();
    end
    cap_valid = 1'b0;
  endtask

  // Drains all held entries, checking order and data, then expects IDLE
  task automatic drain(input int n, input logic [31:0] first);
    logic [31:0] exp_pc;
    for (int i = 0; i < n; i++) begin
      exp_pc = first + 32'(i * 4);
      chk("rd_valid", 64'(rd_valid), 64'(1));
      chk("rd_pc", 64'(rd_pc), 64'(exp_pc));
      chk("rd_instr", 64'(rd_instr), 64'(instr_of(exp_pc)));
      chk("count_drain", 64'(count), 64'(n - i));
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
    end
    if (n == 0) begin
      chk("rd_valid_empty", 64'(rd_valid), 64'(0));
      step();
    end
    chk("state_idle_after_drain", 64'(state), 64'(0));
    chk("rd_valid_idle", 64'(rd_valid), 64'(0));
  endtask

  vec_t vecs [7];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    cap_valid = 1'b0;
    cap_pc    = '0;
    cap_instr = '0;
    mode      = 2'd0;
    trig_pc   = '0;
    arm       = 1'b0;
    stop      = 1'b0;
    rd_ready  = 1'b0;

    vecs[0] = '{2'd1, 32'h0,   20, 1'b0, 16, 1'b0, 1'b0, 32'h00};
    vecs[1] = '{2'd0, 32'h0,   20, 1'b1, 16, 1'b1, 1'b0, 32'h10};
    vecs[2] = '{2'd2, 32'h40,  25, 1'b0, 16, 1'b1, 1'b1, 32'h14};
    vecs[3] = '{2'd3, 32'h0,   10, 1'b1, 10, 1'b0, 1'b0, 32'h00};
    vecs[4] = '{2'd2, 32'h100,  8, 1'b1,  8, 1'b0, 1'b0, 32'h00};
    vecs[5] = '{2'd2, 32'h08,  12, 1'b0,  7, 1'b0, 1'b1, 32'h00};
    vecs[6] = '{2'd0, 32'h0,    0, 1'b1,  0, 1'b0, 1'b0, 32'h00};

    step(); step();
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_triggered", 64'(triggered), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    reset = 1'b1;
    step();

    // Table-driven capture scenarios
    for (int v = 0; v < 7; v++) begin
      mode    = vecs[v].mode;
      trig_pc = vecs[v].trig;
      // Sample presented with arm must not be captured
      cap_valid = 1'b1; cap_pc = 32'hFFF0; cap_instr = 32'h0;
      do_arm();
      cap_valid = 1'b0;
      chk("state_armed", 64'(state), 64'(1));
      chk("count_armed", 64'(count), 64'(0));
      feed(0, vecs[v].nsamp);
      if (vecs[v].do_stop) do_stop();
      chk("state_done", 64'(state), 64'(3));
      chk("count_done", 64'(count), 64'(vecs[v].exp_cnt));
      chk("overflow", 64'(overflow), 64'(vecs[v].exp_ovf));
      chk("triggered", 64'(triggered), 64'(vecs[v].exp_trig));
      drain(vecs[v].exp_cnt, vecs[v].exp_first);
    end

    // Backpressure: output holds while rd_ready is low
    mode = 2'd0;
    do_arm();
    feed(0, 6);
    do_stop();
    for (int i = 0; i < 3; i++) begin
      chk("bp_rd_valid", 64'(rd_valid), 64'(1));
      chk("bp_rd_pc", 64'(rd_pc), 64'(0));
      chk("bp_count", 64'(count), 64'(6));
      step();
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("bp_pop_pc", 64'(rd_pc), 64'(i * 4));
      chk("bp_pop_count", 64'(count), 64'(6 - i));
      step();
    end
    rd_ready = 1'b0;
    chk("bp_idle", 64'(state), 64'(0));

    // arm while ARMED is ignored; stop together with a sample keeps the sample
    mode = 2'd0;
    do_arm();
    feed(0, 2);
    do_arm();
    chk("rearm_state", 64'(state), 64'(1));
    chk("rearm_count", 64'(count), 64'(2));
    cap_valid = 1'b1; cap_pc = 32'h08; cap_instr = instr_of(32'h08);
    stop = 1'b1; step(); stop = 1'b0; cap_valid = 1'b0;
    chk("stopcap_state", 64'(state), 64'(3));
    chk("stopcap_count", 64'(count), 64'(3));
    drain(3, 32'h00);

    // stop in IDLE is ignored; arm in DONE discards unread entries
    do_stop();
    chk("stop_idle", 64'(state), 64'(0));
    do_arm();
    feed(0, 5);
    do_stop();
    chk("done5_count", 64'(count), 64'(5));
    do_arm();
    chk("arm_done_state", 64'(state), 64'(1));
    chk("arm_done_count", 64'(count), 64'(0));
    feed(8, 2);
    do_stop();
    drain(2, 32'h20);

    // Reset in POST with overflow and trigger both set
    mode = 2'd2; trig_pc = 32'h44;
    do_arm();
    feed(0, 19);
    chk("post_state", 64'(state), 64'(2));
    chk("post_overflow", 64'(overflow), 64'(1));
    chk("post_triggered", 64'(triggered), 64'(1));
    reset = 1'b0; step(); reset = 1'b1;
    chk("mid_rst_state", 64'(state), 64'(0));
    chk("mid_rst_count", 64'(count), 64'(0));
    chk("mid_rst_triggered", 64'(triggered), 64'(0));
    chk("mid_rst_overflow", 64'(overflow), 64'(0));
    chk("mid_rst_rd_valid", 64'(rd_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
